zports_ctrl: RTL and testbench
==============================

Name: zports_ctrl

Overview:
- Clocked control/status register block behind the zx-bus port decoder (ports_* interface of the bus glue).
- Owns ROM-window mapping for the W5300 memory window, timed hardware resets for the W5300 and SL811, and interrupt latching/masking toward the Z80 INT line.
- Synchronises the asynchronous Z80 write strobe into the local clock domain and serves readback data combinationally.

Parameters:
- RST_CYCLES, 16'd2000, clocks the chip reset outputs stay asserted per reset pulse (power-on or software).
- RST_W, 16, width of the reset counter; RST_CYCLES must fit in it.

Ports:
- clk  in  1  system clock, at least 4x the Z80 clock.
- rst_n  in  1  asynchronous active-low reset.
- ports_wrena  in  1  write target is a port owned by this block (qualified by ports_addr).
- ports_wrstb_n  in  1  asynchronous Z80 write strobe, active low.
- ports_addr  in  2  register select.
- ports_wrdata  in  8  write data; stable while the strobe is low.
- ports_rddata  out  8  read data for the selected register.
- rommap_win  out  2  Z80 16K window (A15:A14) mapped to the W5300.
- rommap_ena  out  1  ROM-window mapping enable.
- w5300_rst_n  out  1  W5300 hardware reset, active low.
- sl811_rst_n  out  1  SL811 hardware reset, active low.
- w5300_int_n  in  1  W5300 interrupt, asynchronous, active low.
- sl811_int_n  in  1  SL811 interrupt, asynchronous, active low.
- zint_n  out  1  Z80 interrupt request, active low; the top level makes it open-drain.

Behaviour:
- Register map:
  - Addr 0: SL811 address register, not owned here. Writes are ignored; reads return 8'hFF.
  - Addr 1 CFG: [0] rommap_ena, [2:1] rommap_win, [7] write 1 = reset request. Read returns {rst_busy, 4'b0, win, ena}.
  - Addr 2 ISR: [0] W5300 pending, [1] SL811 pending. Writing 1 clears the bit. Read returns {2'b0, raw_sl811, raw_w5300, 2'b0, pend[1:0]}; raw bits are the synchronised levels, active high.
  - Addr 3 IMR: [1:0] per-source mask (1 = enabled), [7] global interrupt enable. Read returns the stored value, with unused bits as 0.
- Write path:
  - ports_wrstb_n goes through a 2-FF synchroniser plus one delay FF.
  - A synchronised high-to-low transition produces a one-clock we_pulse, 2-3 clocks after the strobe falls.
  - The register update happens on we_pulse, using ports_wrena, ports_addr and ports_wrdata sampled directly.
  - Exactly one write per strobe, however long the strobe is held.
- Reset pulse:
  - On rst_n low: counter = RST_CYCLES, both chip resets asserted, rst_busy = 1.
  - The counter decrements each clock; on reaching 0, both chip resets deassert and rst_busy = 0.
  - A CFG write with bit 7 = 1 while idle reloads RST_CYCLES. The same write still updates bits [2:0].
  - A bit-7 request while busy is ignored; it does not restart the count.
- Interrupts:
  - Each int_n input passes a 2-FF synchroniser; an edge detector sets pend[i] on an active-going edge.
  - While rst_busy = 1, edge detection is suppressed and pend is held at 0.
  - A set and a W1C clear in the same cycle: set wins.
  - zint_n = ~(imr[7] & |(pend & imr[1:0])), registered, so it lags the pend change by 1 clock.
- Reset values (async, on rst_n low):
  - rommap_ena=0, rommap_win=2'b00.
  - pend=0, imr=0, zint_n=1.
  - w5300_rst_n=0, sl811_rst_n=0.
  - Synchroniser flops reset to 1 (inactive).
- ports_rddata is combinational from ports_addr; the bus glue gates the bus drive.

Optional Feature:
- ZXNET_INT_EN defined: ISR/IMR logic and zint_n as above.
- ZXNET_INT_EN undefined:
  - pend, imr and the edge detectors are removed.
  - Addr 2 reads {2'b0, raw_sl811, raw_w5300, 4'b0}; addr 3 reads 8'h00.
  - Writes to addr 2 and addr 3 are ignored; zint_n is tied to 1.

Decomposition:
- Package zxnet_pkg: register address constants (REG_SLADDR=0, REG_CFG=1, REG_ISR=2, REG_IMR=3), CFG/ISR/IMR bit-position constants, and the RST_CYCLES default.
- One sub-module, zsync_edge: 2-FF synchroniser plus fall detector, parameterised reset level.
  - Instantiated for the write strobe and for each interrupt input.

Test Plan:
- Power-on: release rst_n → both chip resets low for exactly 2000 clks, then high; CFG reads 8'h80 during the count, 8'h00 after.
- Write CFG 8'h05 with a 3-clk strobe → rommap_ena=1, rommap_win=2'b10 one clk after we_pulse; a 40-clk strobe to ISR with data 8'h03 → exactly one W1C write, pend cleared.
- Write CFG 8'h80 when idle → 2000-clk reset pulse; second 8'h80 at clk 1000 → reset still ends at clk 2000 of the first pulse.
- IMR=8'h81, assert w5300_int_n low → pend[0]=1 within 3 clks, zint_n=0 one clk later; write ISR 8'h01 → zint_n=1; IMR=8'h01 (global off) → zint_n stays 1.
- sl811_int_n falls in the same clk as a W1C of ISR bit 1 → pend[1] remains 1.
- Interrupt edge during an active reset pulse → pend stays 0; read addr 0 → 8'hFF; build without ZXNET_INT_EN → zint_n constant 1, addr 3 reads 8'h00.

Source files
------------

// File: rtl/zxnet_pkg.sv
// ----------------------------------------------------------------------------
// zxnet_pkg
// Shared definitions for the ZX-bus network card control block.
//   - reg_sel_e      : register select values on ports_addr
//   - CFG_* / ISR_* / IMR_* : bit positions inside the control registers
//   - RST_CYCLES_DEFAULT    : default length of a chip reset pulse in clocks
// ----------------------------------------------------------------------------
package zxnet_pkg;

    // Register select on the two-bit port address
    typedef enum logic [1:0] {
        REG_SLADDR = 2'd0,
        REG_CFG    = 2'd1,
        REG_ISR    = 2'd2,
        REG_IMR    = 2'd3
    } reg_sel_e;

    // CFG register layout
    localparam int CFG_ENA_BIT    = 0;
    localparam int CFG_WIN_LSB    = 1;
    localparam int CFG_WIN_MSB    = 2;
    localparam int CFG_RST_BIT    = 7;

    // ISR register layout (pending bits are W1C, raw bits are read-only)
    localparam int ISR_W5300_BIT     = 0;
    localparam int ISR_SL811_BIT     = 1;
    localparam int ISR_RAW_W5300_BIT = 4;
    localparam int ISR_RAW_SL811_BIT = 5;

    // IMR register layout
    localparam int IMR_W5300_BIT  = 0;
    localparam int IMR_SL811_BIT  = 1;
    localparam int IMR_GIE_BIT    = 7;

    // Default chip reset pulse length in system clocks
    localparam int unsigned RST_CYCLES_DEFAULT = 2000;

    // Value returned for the SL811 address port, which lives elsewhere
    localparam logic [7:0] SLADDR_READ_VALUE = 8'hFF;

endpackage : zxnet_pkg

// File: rtl/zsync_edge.sv
// ----------------------------------------------------------------------------
// zsync_edge
// Two-flop synchroniser for an asynchronous level followed by one delay flop,
// giving a one-clock pulse when the synchronised level goes high-to-low.
//   clk      in  : local clock
//   rst_n    in  : asynchronous active-low reset
//   async_i  in  : asynchronous input level
//   level_o  out : synchronised level
//   fall_o   out : one-clock pulse on a synchronised falling edge
// Parameter RESET_VAL sets the value all three flops take in reset, which
// should be the inactive level of the input so no edge is seen at start-up.
// ----------------------------------------------------------------------------
module zsync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Synchroniser chain plus the delay stage used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            dly_q  <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = dly_q & ~sync_q;

endmodule : zsync_edge

// File: rtl/zports_ctrl.sv
// ----------------------------------------------------------------------------
// zports_ctrl
// Control/status register block behind the zx-bus port decoder. Holds the
// ROM-window mapping for the W5300, generates timed hardware resets for the
// W5300 and SL811, and latches/masks their interrupts toward Z80 INT.
//
// Ports
//   clk            in  : system clock (>= 4x Z80 clock)
//   rst_n          in  : asynchronous active-low reset
//   ports_wrena    in  : write targets a port owned by this block
//   ports_wrstb_n  in  : asynchronous Z80 write strobe, active low
//   ports_addr     in  : register select (see zxnet_pkg::reg_sel_e)
//   ports_wrdata   in  : write data, stable while strobe is low
//   ports_rddata   out : combinational read data for ports_addr
//   rommap_win     out : Z80 16K window mapped to the W5300
//   rommap_ena     out : ROM-window mapping enable
//   w5300_rst_n    out : W5300 hardware reset, active low
//   sl811_rst_n    out : SL811 hardware reset, active low
//   w5300_int_n    in  : W5300 interrupt, asynchronous, active low
//   sl811_int_n    in  : SL811 interrupt, asynchronous, active low
//   zint_n         out : Z80 interrupt request, active low
//
// Build option
//   ZXNET_INT_EN : when defined, the ISR/IMR registers and interrupt
//                  generation are present; otherwise zint_n is tied high,
//                  ISR shows only raw levels and IMR reads as zero.
// ----------------------------------------------------------------------------
module zports_ctrl
    import zxnet_pkg::*;
#(
    parameter int unsigned         RST_W      = 16,
    parameter logic [RST_W-1:0]    RST_CYCLES = RST_W'(RST_CYCLES_DEFAULT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ports_wrena,
    input  logic       ports_wrstb_n,
    input  logic [1:0] ports_addr,
    input  logic [7:0] ports_wrdata,
    output logic [7:0] ports_rddata,
    output logic [1:0] rommap_win,
    output logic       rommap_ena,
    output logic       w5300_rst_n,
    output logic       sl811_rst_n,
    input  logic       w5300_int_n,
    input  logic       sl811_int_n,
    output logic       zint_n
);

    logic             wrLevel;
    logic             wePulse;
    logic             w5300Level;
    logic             w5300Fall;
    logic             sl811Level;
    logic             sl811Fall;
    logic             regWe;
    reg_sel_e         regSel;
    logic             rstBusy;
    logic [1:0]       rawInt;

    logic             rommapEna_q, rommapEna_d;
    logic [1:0]       rommapWin_q, rommapWin_d;
    logic [RST_W-1:0] rstCnt_q,    rstCnt_d;
    logic             chipRst_q,   chipRst_d;

    // The write strobe and both interrupt lines are all inactive-high
    // asynchronous signals, so they share the same synchroniser/edge cell.
    zsync_edge #(.RESET_VAL(1'b1)) u_wrstb_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ports_wrstb_n),
        .level_o (wrLevel),
        .fall_o  (wePulse)
    );

    zsync_edge #(.RESET_VAL(1'b1)) u_w5300_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (w5300_int_n),
        .level_o (w5300Level),
        .fall_o  (w5300Fall)
    );

    zsync_edge #(.RESET_VAL(1'b1)) u_sl811_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (sl811_int_n),
        .level_o (sl811Level),
        .fall_o  (sl811Fall)
    );

    // Address, enable and data are sampled directly: the Z80 holds them
    // stable for the whole strobe, which outlasts the synchroniser delay.
    assign regSel  = reg_sel_e'(ports_addr);
    assign regWe   = wePulse & ports_wrena;
    assign rstBusy = (rstCnt_q != '0);
    assign rawInt  = {~sl811Level, ~w5300Level};

    // CFG register and reset pulse counter. A reset request only reloads the
    // counter when idle, so a repeated request cannot stretch a pulse, but
    // the mapping bits in the same write are always taken.
    always_comb begin
        rommapEna_d = rommapEna_q;
        rommapWin_d = rommapWin_q;
        rstCnt_d    = rstBusy ? (rstCnt_q - 1'b1) : '0;
        if (regWe && (regSel == REG_CFG)) begin
            rommapEna_d = ports_wrdata[CFG_ENA_BIT];
            rommapWin_d = ports_wrdata[CFG_WIN_MSB:CFG_WIN_LSB];
            if (ports_wrdata[CFG_RST_BIT] && !rstBusy) begin
                rstCnt_d = RST_CYCLES;
            end
        end
        chipRst_d = (rstCnt_d == '0);
    end

    // Control state flops. Coming out of reset the counter is preloaded so
    // the chips get a full-length power-on reset pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rommapEna_q <= 1'b0;
            rommapWin_q <= 2'b00;
            rstCnt_q    <= RST_CYCLES;
            chipRst_q   <= 1'b0;
        end else begin
            rommapEna_q <= rommapEna_d;
            rommapWin_q <= rommapWin_d;
            rstCnt_q    <= rstCnt_d;
            chipRst_q   <= chipRst_d;
        end
    end

    assign rommap_ena  = rommapEna_q;
    assign rommap_win  = rommapWin_q;
    assign w5300_rst_n = chipRst_q;
    assign sl811_rst_n = chipRst_q;

`ifdef ZXNET_INT_EN

    logic [1:0] pend_q, pend_d;
    logic [1:0] imrSrc_q, imrSrc_d;
    logic       imrGie_q, imrGie_d;
    logic       zint_q, zint_d;
    logic [1:0] pendSet;
    logic [1:0] pendClr;
    logic       unusedBits;

    // Pending bits: a new edge beats a simultaneous W1C so no interrupt is
    // lost. While the chips are held in reset their interrupt pins are
    // meaningless, so pending state is forced clear.
    always_comb begin
        pendSet  = {sl811Fall, w5300Fall};
        pendClr  = 2'b00;
        imrSrc_d = imrSrc_q;
        imrGie_d = imrGie_q;
        if (regWe && (regSel == REG_ISR)) begin
            pendClr = ports_wrdata[ISR_SL811_BIT:ISR_W5300_BIT];
        end
        if (regWe && (regSel == REG_IMR)) begin
            imrSrc_d = ports_wrdata[IMR_SL811_BIT:IMR_W5300_BIT];
            imrGie_d = ports_wrdata[IMR_GIE_BIT];
        end
        if (rstBusy) begin
            pend_d = 2'b00;
        end else begin
            pend_d = (pend_q & ~pendClr) | pendSet;
        end
        zint_d = ~(imrGie_q & |(pend_q & imrSrc_q));
    end

    // Interrupt state flops; zint_n is registered from the current pending
    // and mask state, so it follows a pending change one clock later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 2'b00;
            imrSrc_q <= 2'b00;
            imrGie_q <= 1'b0;
            zint_q   <= 1'b1;
        end else begin
            pend_q   <= pend_d;
            imrSrc_q <= imrSrc_d;
            imrGie_q <= imrGie_d;
            zint_q   <= zint_d;
        end
    end

    assign zint_n     = zint_q;
    assign unusedBits = ^{wrLevel, ports_wrdata[6:3]};

    // Readback mux with the interrupt registers present
    always_comb begin
        ports_rddata = 8'h00;
        case (regSel)
            REG_SLADDR: ports_rddata = SLADDR_READ_VALUE;
            REG_CFG:    ports_rddata = {rstBusy, 4'b0000, rommapWin_q, rommapEna_q};
            REG_ISR:    ports_rddata = {2'b00, rawInt, 2'b00, pend_q};
            REG_IMR:    ports_rddata = {imrGie_q, 5'b00000, imrSrc_q};
            default:    ports_rddata = 8'h00;
        endcase
    end

`else

    logic unusedBits;

    assign zint_n     = 1'b1;
    assign unusedBits = ^{wrLevel, w5300Fall, sl811Fall, ports_wrdata[6:3]};

    // Readback mux without interrupt logic: ISR carries raw levels only
    always_comb begin
        ports_rddata = 8'h00;
        case (regSel)
            REG_SLADDR: ports_rddata = SLADDR_READ_VALUE;
            REG_CFG:    ports_rddata = {rstBusy, 4'b0000, rommapWin_q, rommapEna_q};
            REG_ISR:    ports_rddata = {2'b00, rawInt, 4'b0000};
            REG_IMR:    ports_rddata = 8'h00;
            default:    ports_rddata = 8'h00;
        endcase
    end

`endif

endmodule : zports_ctrl

// File: tb/tb_zports_ctrl.sv
// ----------------------------------------------------------------------------
// tb_zports_ctrl
// Directed bench for zports_ctrl: power-on reset pulse, CFG writes, software
// reset pulse with an overlapping request, readback of addr 0/2/3, and the
// interrupt path (only when built with ZXNET_INT_EN).
// ----------------------------------------------------------------------------
module tb_zports_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ports_wrena;
    logic       ports_wrstb_n;
    logic [1:0] ports_addr;
    logic [7:0] ports_wrdata;
    logic [7:0] ports_rddata;
    logic [1:0] rommap_win;
    logic       rommap_ena;
    logic       w5300_rst_n;
    logic       sl811_rst_n;
    logic       w5300_int_n;
    logic       sl811_int_n;
    logic       zint_n;

    int passCount;
    int totalCount;
    int pulseLen;
    int found;

    zports_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ports_wrena   (ports_wrena),
        .ports_wrstb_n (ports_wrstb_n),
        .ports_addr    (ports_addr),
        .ports_wrdata  (ports_wrdata),
        .ports_rddata  (ports_rddata),
        .rommap_win    (rommap_win),
        .rommap_ena    (rommap_ena),
        .w5300_rst_n   (w5300_rst_n),
        .sl811_rst_n   (sl811_rst_n),
        .w5300_int_n   (w5300_int_n),
        .sl811_int_n   (sl811_int_n),
        .zint_n        (zint_n)
    );

    // 100 MHz free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure with both values
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // One Z80 port write: strobe low for holdClks clocks, then the bus stays
    // valid a few more clocks so the synchronised pulse sees stable data.
    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data, input int holdClks);
        @(negedge clk);
        ports_wrena   = 1'b1;
        ports_addr    = addr;
        ports_wrdata  = data;
        ports_wrstb_n = 1'b0;
        repeat (holdClks) @(negedge clk);
        ports_wrstb_n = 1'b1;
        repeat (4) @(negedge clk);
        ports_wrena   = 1'b0;
    endtask

    // Combinational readback of one register
    task automatic readReg(input logic [1:0] addr, output logic [7:0] data);
        ports_addr = addr;
        #1;
        data = ports_rddata;
    endtask

    initial begin
        logic [7:0] rd;
        passCount     = 0;
        totalCount    = 0;
        rst_n         = 1'b1;
        ports_wrena   = 1'b0;
        ports_wrstb_n = 1'b1;
        ports_addr    = 2'd0;
        ports_wrdata  = 8'h00;
        w5300_int_n   = 1'b1;
        sl811_int_n   = 1'b1;

        // Reset state while rst_n is held low
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst w5300_rst_n", {15'd0, w5300_rst_n}, 16'd0);
        checkOutput("rst sl811_rst_n", {15'd0, sl811_rst_n}, 16'd0);
        checkOutput("rst zint_n", {15'd0, zint_n}, 16'd1);
        checkOutput("rst rommap", {13'd0, rommap_win, rommap_ena}, 16'd0);
        readReg(2'd1, rd);
        checkOutput("rst cfg read", {8'd0, rd}, 16'h0080);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Power-on pulse length, CFG busy readback at the midpoint
        ports_addr = 2'd1;
        pulseLen   = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            pulseLen++;
            if (pulseLen == 1000) checkOutput("por cfg busy", {8'd0, ports_rddata}, 16'h0080);
            if (w5300_rst_n) break;
        end
        checkOutput("por pulse len", 16'(pulseLen), 16'd2000);
        checkOutput("por sl811 high", {15'd0, sl811_rst_n}, 16'd1);
        readReg(2'd1, rd);
        checkOutput("por cfg idle", {8'd0, rd}, 16'h0000);

        // CFG write with a short strobe
        applyStimulus(2'd1, 8'h05, 3);
        #1;
        checkOutput("cfg ena", {15'd0, rommap_ena}, 16'd1);
        checkOutput("cfg win", {14'd0, rommap_win}, 16'd2);
        readReg(2'd1, rd);
        checkOutput("cfg read 05", {8'd0, rd}, 16'h0005);

        // Software reset pulse, with a second request about halfway through
        fork
            begin
                found = 0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk);
                    #1;
                    if (!w5300_rst_n) begin
                        found = 1;
                        break;
                    end
                end
                checkOutput("sw pulse start", 16'(found), 16'd1);
                pulseLen = 0;
                if (found == 1) begin
                    for (int i = 0; i < 3000; i++) begin
                        @(posedge clk);
                        #1;
                        pulseLen++;
                        if (w5300_rst_n) break;
                    end
                end
                checkOutput("sw pulse len", 16'(pulseLen), 16'd2000);
            end
            begin
                applyStimulus(2'd1, 8'h80, 3);
                #1;
                checkOutput("sw cfg clears map", {13'd0, rommap_win, rommap_ena}, 16'd0);
                repeat (990) @(negedge clk);
                applyStimulus(2'd1, 8'h83, 3);
                #1;
                readReg(2'd1, rd);
                checkOutput("busy cfg read 83", {8'd0, rd}, 16'h0083);
            end
        join
        checkOutput("post pulse ena", {15'd0, rommap_ena}, 16'd1);
        checkOutput("post pulse win", {14'd0, rommap_win}, 16'd1);
        readReg(2'd1, rd);
        checkOutput("post pulse cfg", {8'd0, rd}, 16'h0003);

        // SL811 address port is not owned here
        applyStimulus(2'd0, 8'h12, 3);
        readReg(2'd0, rd);
        checkOutput("addr0 read", {8'd0, rd}, 16'h00FF);

`ifdef ZXNET_INT_EN
        // Enable W5300 source plus global enable, then raise its interrupt
        applyStimulus(2'd3, 8'h81, 3);
        readReg(2'd3, rd);
        checkOutput("imr read 81", {8'd0, rd}, 16'h0081);
        ports_addr = 2'd2;
        @(negedge clk);
        w5300_int_n = 1'b0;
        found = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (ports_rddata[0]) begin
                found = 1;
                break;
            end
        end
        checkOutput("pend w5300 set", 16'(found), 16'd1);
        checkOutput("zint lag", {15'd0, zint_n}, 16'd1);
        @(posedge clk);
        #1;
        checkOutput("zint asserted", {15'd0, zint_n}, 16'd0);

        // W1C clears pending and releases zint_n
        applyStimulus(2'd2, 8'h01, 3);
        #1;
        checkOutput("zint released", {15'd0, zint_n}, 16'd1);
        readReg(2'd2, rd);
        checkOutput("isr after w1c", {8'd0, rd}, 16'h0010);

        // Global enable off: pending sets but zint_n stays high
        w5300_int_n = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(2'd3, 8'h01, 3);
        w5300_int_n = 1'b0;
        repeat (6) @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("isr gie off", {8'd0, rd}, 16'h0011);
        checkOutput("zint gie off", {15'd0, zint_n}, 16'd1);

        // Long strobe W1C of both bits
        applyStimulus(2'd2, 8'h03, 40);
        readReg(2'd2, rd);
        checkOutput("isr long w1c", {8'd0, rd}, 16'h0010);

        // SL811 edge lands on the same clock as a W1C of its bit
        @(negedge clk);
        ports_wrena   = 1'b1;
        ports_addr    = 2'd2;
        ports_wrdata  = 8'h02;
        ports_wrstb_n = 1'b0;
        sl811_int_n   = 1'b0;
        repeat (3) @(negedge clk);
        ports_wrstb_n = 1'b1;
        repeat (4) @(negedge clk);
        ports_wrena   = 1'b0;
        readReg(2'd2, rd);
        checkOutput("set beats clear", {8'd0, rd}, 16'h0032);

        // Edges during a reset pulse are suppressed
        w5300_int_n = 1'b1;
        sl811_int_n = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(2'd1, 8'h80, 3);
        w5300_int_n = 1'b0;
        repeat (10) @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("pend held in reset", {8'd0, rd}, 16'h0010);
`else
        // Without interrupt logic: raw levels only, IMR reads zero
        applyStimulus(2'd3, 8'h81, 3);
        readReg(2'd3, rd);
        checkOutput("imr reads zero", {8'd0, rd}, 16'h0000);
        @(negedge clk);
        w5300_int_n = 1'b0;
        repeat (5) @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("isr raw w5300", {8'd0, rd}, 16'h0010);
        checkOutput("zint tied w5300", {15'd0, zint_n}, 16'd1);
        sl811_int_n = 1'b1;
        @(negedge clk);
        sl811_int_n = 1'b0;
        repeat (5) @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("isr raw both", {8'd0, rd}, 16'h0030);
        applyStimulus(2'd2, 8'h03, 40);
        readReg(2'd2, rd);
        checkOutput("isr write ignored", {8'd0, rd}, 16'h0030);
        checkOutput("zint tied both", {15'd0, zint_n}, 16'd1);
        w5300_int_n = 1'b1;
        sl811_int_n = 1'b1;
        repeat (5) @(negedge clk);
        readReg(2'd2, rd);
        checkOutput("isr raw idle", {8'd0, rd}, 16'h0000);
`endif

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule : tb_zports_ctrl
